// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: sequencer state encoding, frame opcodes and
// ALU function codes used by the sequencer, the ALU and the bench.
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGetA,
        StGetB,
        StGetFun,
        StIssue,
        StWait,
        StSend
    } seq_state_e;

    localparam logic [7:0] OpcFull = 8'hCC;
    localparam logic [7:0] OpcFun  = 8'hDD;

    localparam logic [3:0] FunAdd = 4'b0000;
    localparam logic [3:0] FunSub = 4'b0001;
    localparam logic [3:0] FunAnd = 4'b0010;
    localparam logic [3:0] FunOr  = 4'b0011;
    localparam logic [3:0] FunXor = 4'b0100;
    localparam logic [3:0] FunNot = 4'b0101;
    localparam logic [3:0] FunShr = 4'b1101;
    localparam logic [3:0] FunShl = 4'b1110;
    // The ALU never raises valid for this code; the sequencer times out.
    localparam logic [3:0] FunNop = 4'b1111;

endpackage

// File: rtl/alu_cmd_timeout.sv
// WAIT-state cycle counter with terminal-count detect for the ALU sequencer.
module alu_cmd_timeout #(
    parameter int unsigned WAIT_MAX = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    logic [CntW-1:0] cnt_q;

    assign expired = (cnt_q == CntW'(WAIT_MAX - 1));

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Byte-stream command sequencer: parses ALU frames, pulses ALU_EN once per
// well-formed frame and returns the result (or a timeout) over a TX handshake.
module alu_cmd_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH = 8,
    parameter int unsigned              FUN_WIDTH  = 4,
    parameter int unsigned              WAIT_MAX   = 2,
    parameter logic [DATA_WIDTH-1:0]    CMD_FULL   = DATA_WIDTH'(OpcFull),
    parameter logic [DATA_WIDTH-1:0]    CMD_FUN    = DATA_WIDTH'(OpcFun)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_VALID,
    output logic                  RX_READY,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  ALU_EN,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  ALU_OUT_VALID,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_ERR,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    output logic                  FRAME_ERR,
    output logic                  BUSY
);

    seq_state_e            state_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, tx_data_q;
    logic [FUN_WIDTH-1:0]  fun_q;
    logic                  alu_en_q, tx_err_q, tx_valid_q, frame_err_q;
    logic                  rx_fire, tmo_expired;

    always_comb begin
        RX_READY = 1'b0;
        unique case (state_q)
            StIdle, StGetA, StGetB, StGetFun: RX_READY = 1'b1;
            default:                          RX_READY = 1'b0;
        endcase
    end

    assign BUSY    = (state_q != StIdle);
    assign rx_fire = RX_VALID && RX_READY;

    alu_cmd_timeout #(
        .WAIT_MAX (WAIT_MAX)
    ) u_timeout (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (state_q == StIssue),
        .en      (state_q == StWait),
        .expired (tmo_expired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= '0;
            tx_data_q   <= '0;
            tx_err_q    <= 1'b0;
            tx_valid_q  <= 1'b0;
            alu_en_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            alu_en_q    <= 1'b0;
            frame_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rx_fire) begin
                        if (RX_DATA == CMD_FULL) begin
                            state_q <= StGetA;
                        end else if (RX_DATA == CMD_FUN) begin
                            state_q <= StGetFun;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                StGetA: begin
                    if (rx_fire) begin
                        a_q     <= RX_DATA;
                        state_q <= StGetB;
                    end
                end
                StGetB: begin
                    if (rx_fire) begin
                        b_q     <= RX_DATA;
                        state_q <= StGetFun;
                    end
                end
                StGetFun: begin
                    if (rx_fire) begin
                        fun_q    <= RX_DATA[FUN_WIDTH-1:0];
                        alu_en_q <= 1'b1;  // registered so it is high exactly during ISSUE
                        state_q  <= StIssue;
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (ALU_OUT_VALID) begin
                        tx_data_q  <= ALU_OUT;
                        tx_err_q   <= 1'b0;
                        tx_valid_q <= 1'b1;
                        state_q    <= StSend;
                    end else if (tmo_expired) begin
                        tx_data_q  <= '0;
                        tx_err_q   <= 1'b1;
                        tx_valid_q <= 1'b1;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    if (TX_READY) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ALU_A     = a_q;
    assign ALU_B     = b_q;
    assign ALU_FUN   = fun_q;
    assign ALU_EN    = alu_en_q;
    assign TX_DATA   = tx_data_q;
    assign TX_ERR    = tx_err_q;
    assign TX_VALID  = tx_valid_q;
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small registered ALU model.
module tb_alu_cmd_sequencer;
    import alu_ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY;
    logic [7:0] ALU_A, ALU_B;
    logic [3:0] ALU_FUN;
    logic       ALU_EN;
    logic [7:0] ALU_OUT;
    logic       ALU_OUT_VALID;
    logic [7:0] TX_DATA;
    logic       TX_ERR;
    logic       TX_VALID;
    logic       TX_READY;
    logic       FRAME_ERR;
    logic       BUSY;

    int n_checks = 0;
    int n_errors = 0;
    int en_pulses = 0;

    always #5 CLK = ~CLK;

    alu_cmd_sequencer #(
        .DATA_WIDTH (8),
        .FUN_WIDTH  (4),
        .WAIT_MAX   (2),
        .CMD_FULL   (8'hCC),
        .CMD_FUN    (8'hDD)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_DATA       (RX_DATA),
        .RX_VALID      (RX_VALID),
        .RX_READY      (RX_READY),
        .ALU_A         (ALU_A),
        .ALU_B         (ALU_B),
        .ALU_FUN       (ALU_FUN),
        .ALU_EN        (ALU_EN),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_VALID (ALU_OUT_VALID),
        .TX_DATA       (TX_DATA),
        .TX_ERR        (TX_ERR),
        .TX_VALID      (TX_VALID),
        .TX_READY      (TX_READY),
        .FRAME_ERR     (FRAME_ERR),
        .BUSY          (BUSY)
    );

    // Registered ALU: result one edge after ALU_EN, never valid for FunNop.
    always @(posedge CLK) begin
        if (RST) begin
            ALU_OUT_VALID <= 1'b0;
            ALU_OUT       <= 8'h00;
        end else begin
            ALU_OUT_VALID <= ALU_EN && (ALU_FUN != FunNop);
            if (ALU_EN) begin
                case (ALU_FUN)
                    FunAdd:  ALU_OUT <= ALU_A + ALU_B;
                    FunSub:  ALU_OUT <= ALU_A - ALU_B;
                    FunAnd:  ALU_OUT <= ALU_A & ALU_B;
                    FunOr:   ALU_OUT <= ALU_A | ALU_B;
                    FunXor:  ALU_OUT <= ALU_A ^ ALU_B;
                    default: ALU_OUT <= 8'h00;
                endcase
            end
            if (ALU_EN) en_pulses <= en_pulses + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        step();
        RX_VALID = 1'b0;
    endtask

    // Called right after the FUN byte edge; returns cycles until TX_VALID.
    task automatic wait_tx(input string tag, output int lat);
        lat = 1;
        while (!TX_VALID && lat < 20) begin
            step();
            lat++;
        end
        if (!TX_VALID) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_tx_timeout: TX_VALID never rose within %0d cycles", tag, lat);
        end
    endtask

    initial begin
        int lat;
        int en0;
        logic [7:0] held;

        RST      = 1'b1;
        RX_DATA  = 8'h00;
        RX_VALID = 1'b0;
        TX_READY = 1'b1;
        step();
        step();
        RST = 1'b0;

        // Reset state
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_rx_ready", RX_READY, 1);
        check_eq("rst_alu_en", ALU_EN, 0);
        check_eq("rst_tx_valid", TX_VALID, 0);
        check_eq("rst_tx_err", TX_ERR, 0);
        check_eq("rst_tx_data", TX_DATA, 0);
        check_eq("rst_frame_err", FRAME_ERR, 0);
        check_eq("rst_alu_a", ALU_A, 0);
        check_eq("rst_alu_fun", ALU_FUN, 0);

        // Full frame ADD: 0x12 + 0x34 = 0x46
        en0 = en_pulses;
        send_byte(8'hCC);
        check_eq("full_busy", BUSY, 1);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte({4'h0, FunAdd});
        check_eq("add_alu_en_issue", ALU_EN, 1);
        check_eq("add_rx_ready_issue", RX_READY, 0);
        wait_tx("add", lat);
        check_eq("add_latency", lat, 3);
        check_eq("add_tx_data", TX_DATA, 8'h46);
        check_eq("add_tx_err", TX_ERR, 0);
        check_eq("add_en_pulses", en_pulses - en0, 1);
        step();
        check_eq("add_back_idle", BUSY, 0);
        check_eq("add_tx_valid_drop", TX_VALID, 0);

        // Function-only SUB reuses stored operands: 0x12 - 0x34 = 0xDE
        send_byte(8'hDD);
        check_eq("fun_a_kept", ALU_A, 8'h12);
        check_eq("fun_b_kept", ALU_B, 8'h34);
        send_byte(8'hF1);  // upper nibble ignored
        check_eq("fun_code", ALU_FUN, FunSub);
        wait_tx("sub", lat);
        check_eq("sub_latency", lat, 3);
        check_eq("sub_tx_data", TX_DATA, 8'hDE);
        step();

        // FUN = 0xF: no ALU valid -> timeout after WAIT_MAX+2 cycles
        send_byte(8'hCC);
        send_byte(8'h05);
        send_byte(8'h07);
        send_byte(8'h0F);
        wait_tx("tmo", lat);
        check_eq("tmo_latency", lat, 4);
        check_eq("tmo_tx_err", TX_ERR, 1);
        check_eq("tmo_tx_data", TX_DATA, 0);
        step();
        check_eq("tmo_back_idle", BUSY, 0);

        // Unknown opcode
        send_byte(8'h55);
        check_eq("ferr_pulse", FRAME_ERR, 1);
        check_eq("ferr_idle", BUSY, 0);
        step();
        check_eq("ferr_one_cycle", FRAME_ERR, 0);
        send_byte(8'hCC);
        send_byte(8'hF0);
        send_byte(8'h0F);
        send_byte({4'h0, FunOr});
        wait_tx("or", lat);
        check_eq("or_tx_data", TX_DATA, 8'hFF);
        check_eq("or_tx_err", TX_ERR, 0);
        step();

        // Backpressure: TX_READY low, RX bytes injected in SEND
        TX_READY = 1'b0;
        send_byte(8'hCC);
        send_byte(8'h10);
        send_byte(8'h01);
        send_byte({4'h0, FunSub});
        wait_tx("bp", lat);
        held = TX_DATA;
        check_eq("bp_tx_data", TX_DATA, 8'h0F);
        for (int i = 0; i < 5; i++) begin
            RX_DATA  = 8'hCC;
            RX_VALID = 1'b1;
            step();
            check_eq("bp_hold_data", TX_DATA, held);
            check_eq("bp_hold_valid", TX_VALID, 1);
            check_eq("bp_rx_ready", RX_READY, 0);
        end
        RX_VALID = 1'b0;
        TX_READY = 1'b1;
        step();
        check_eq("bp_accept_idle", BUSY, 0);
        check_eq("bp_accept_valid", TX_VALID, 0);
        step();
        check_eq("bp_not_consumed", BUSY, 0);

        // Reset in GET_B
        send_byte(8'hCC);
        send_byte(8'h11);
        check_eq("getb_a_loaded", ALU_A, 8'h11);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_eq("rstb_idle", BUSY, 0);
        check_eq("rstb_a", ALU_A, 0);
        check_eq("rstb_b", ALU_B, 0);
        check_eq("rstb_fun", ALU_FUN, 0);
        check_eq("rstb_tx_valid", TX_VALID, 0);
        check_eq("rstb_alu_en", ALU_EN, 0);

        // Reset in WAIT
        send_byte(8'hCC);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte({4'h0, FunXor});
        step();
        check_eq("wait_busy", BUSY, 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_eq("rstw_idle", BUSY, 0);
        check_eq("rstw_a", ALU_A, 0);
        check_eq("rstw_fun", ALU_FUN, 0);
        check_eq("rstw_tx_valid", TX_VALID, 0);
        check_eq("rstw_alu_en", ALU_EN, 0);
        step();
        step();
        check_eq("rstw_no_result", TX_VALID, 0);

        // CMD_FUN right after reset uses A = B = 0
        send_byte(8'hDD);
        send_byte({4'h0, FunOr});
        wait_tx("zero", lat);
        check_eq("zero_tx_data", TX_DATA, 8'h00);
        check_eq("zero_tx_err", TX_ERR, 0);
        check_eq("zero_latency", lat, 3);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Byte-stream command sequencer that owns the system ALU. It receives ALU command frames from the receive-side byte stream, latches operands and function code, and pulses the ALU enable for exactly one cycle. It then captures the ALU result and returns it over a valid/ready transmit handshake, so the ALU is never enabled outside a complete, well-formed command.

## Interface
- `DATA_WIDTH`, 8: operand, result and byte-stream width.
- `FUN_WIDTH`, 4: ALU function code width.
- `WAIT_MAX`, 2: number of cycles in WAIT before a missing ALU valid is declared a timeout; must be ≥1.
- `CMD_FULL`, 8'hCC: opcode for a full frame (A, B, FUN follow).
- `CMD_FUN`, 8'hDD: opcode for a function-only frame (FUN follows; stored A/B reused).
- CLK  in  1  single clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- RX_DATA  in  DATA_WIDTH  incoming frame byte.
- RX_VALID  in  1  RX_DATA valid this cycle; single-cycle pulse per byte, no backpressure upstream.
- RX_READY  out  1  high in IDLE and GET_* states; a byte is accepted iff RX_VALID & RX_READY.
- ALU_A, ALU_B  out  DATA_WIDTH each  stored operands, driven continuously.
- ALU_FUN  out  FUN_WIDTH  stored function code, driven continuously.
- ALU_EN  out  1  ALU enable; high only in ISSUE.
- ALU_OUT  in  DATA_WIDTH  registered ALU result.
- ALU_OUT_VALID  in  1  ALU result valid.
- TX_DATA  out  DATA_WIDTH  result byte.
- TX_ERR  out  1  qualifies TX_DATA: 1 = timeout, TX_DATA = 0.
- TX_VALID  out  1  result available.
- TX_READY  in  1  downstream accepts when TX_VALID & TX_READY.
- FRAME_ERR  out  1  one-cycle pulse when an unknown opcode is accepted in IDLE.
- BUSY  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, GET_A, GET_B, GET_FUN, ISSUE, WAIT, SEND.
- IDLE: accepted byte == CMD_FULL → GET_A; == CMD_FUN → GET_FUN; any other value → stay in IDLE, pulse FRAME_ERR next cycle.
- GET_A / GET_B: an accepted byte loads operand register A / B, then advances to GET_B / GET_FUN. With no RX_VALID the state holds indefinitely; there is no inter-byte timeout.
- GET_FUN: an accepted byte loads FUN ← RX_DATA[FUN_WIDTH-1:0]; upper bits are ignored. → ISSUE.
- ISSUE: ALU_EN = 1 for exactly this cycle. → WAIT, wait counter cleared.
- WAIT: ALU_EN = 0.
  - If ALU_OUT_VALID = 1: capture TX_DATA ← ALU_OUT, TX_ERR ← 0. → SEND.
  - Else if the counter reaches WAIT_MAX-1: TX_DATA ← 0, TX_ERR ← 1. → SEND. This covers FUN = 4'b1111, for which the ALU never asserts valid.
  - Else the counter increments.
- SEND: TX_VALID = 1 with TX_DATA/TX_ERR held stable until TX_READY; the accepting cycle → IDLE.
- Operand and FUN registers persist across frames and are changed only by GET_* or reset. A CMD_FUN frame before any CMD_FULL uses A = B = 0.
- RX bytes arriving in ISSUE/WAIT/SEND are dropped silently (RX_READY = 0).
- Reset values: state IDLE; A, B, FUN, TX_DATA = 0; TX_ERR, TX_VALID, ALU_EN, FRAME_ERR, BUSY = 0; RX_READY = 1 from the first cycle after reset.
- Reset mid-frame or mid-operation: return to IDLE on that edge; any pending result is discarded; ALU_EN is low on the next cycle.

## Timing
- FUN byte accepted at edge n → ALU_EN high in cycle n+1.
- ALU result registers at edge n+2; WAIT samples ALU_OUT_VALID in cycle n+2.
- TX_VALID is high from cycle n+3: 3-cycle latency from the FUN byte to TX_VALID.
- Timeout path: TX_VALID rises WAIT_MAX+2 cycles after the FUN byte.
- A new frame's opcode can be accepted in the cycle after the TX handshake completes.
- All outputs are registered, except RX_READY and BUSY, which are decoded from state.

## Structure
- Shared package (`alu_ctrl_pkg`) holds the state enum, the CMD_FULL/CMD_FUN opcodes, and ALU function-code constants (ADD = 4'b0000 … SHL = 4'b1110). The function-code constants are shared with the ALU and the bench.
- Single module. The optional sub-module `alu_cmd_timeout` contains the WAIT counter and its terminal-count compare.

## Test plan
- Full frame CC, 0x12, 0x34, 0x00 (ADD) with TX_READY tied high → ALU_EN pulses once; TX_DATA = 0x46, TX_ERR = 0, TX_VALID 3 cycles after the FUN byte.
- Function-only frame DD, 0x01 (SUB) after the previous frame → ALU_A/ALU_B are still 0x12/0x34; TX_DATA = 0xDE.
- Frame CC, 0x05, 0x07, 0x0F → no ALU_OUT_VALID; TX_ERR = 1, TX_DATA = 0 after WAIT_MAX+2 cycles.
- Byte 0x55 in IDLE → FRAME_ERR pulses once, state stays IDLE; a following CC frame processes normally.
- Hold TX_READY low for 5 cycles and inject RX bytes during SEND → TX_DATA stable and RX_READY = 0 throughout; on accept the block returns to IDLE and the injected bytes are not consumed.
- Assert RST in GET_B and again in WAIT → IDLE next cycle, A = B = FUN = 0, TX_VALID = 0, ALU_EN = 0.
